// File: rtl/rv_gpio_pkg.sv
// Shared constants for the rv_gpio peripheral: register byte offsets and pin limit.
package rv_gpio_pkg;

    localparam int unsigned GPIO_MAXBITS = 32;

    localparam logic [4:0] GPIO_OUT  = 5'h00;
    localparam logic [4:0] GPIO_IN   = 5'h04;
    localparam logic [4:0] GPIO_DIR  = 5'h08;
    localparam logic [4:0] GPIO_IEN  = 5'h0C;
    localparam logic [4:0] GPIO_STAT = 5'h10;
    localparam logic [4:0] GPIO_EDGE = 5'h14;
    localparam logic [4:0] GPIO_SET  = 5'h18;
    localparam logic [4:0] GPIO_CLR  = 5'h1C;

    // Word index used by the bus decode (adr[4:2]).
    function automatic logic [2:0] reg_idx(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/rv_gpio_in.sv
// Per-pin input path: synchroniser, optional debounce (RV_GPIO_DEBOUNCE_EN) and edge detector.
module rv_gpio_in #(
    parameter int unsigned NSYNC = 2
`ifdef RV_GPIO_DEBOUNCE_EN
    ,
    parameter int unsigned DBC_W = 16
`endif
) (
    input  logic             clk,
    input  logic             xreset,
    input  logic             pin,
    input  logic             edge_sel,
`ifdef RV_GPIO_DEBOUNCE_EN
    input  logic [DBC_W-1:0] dbc,
`endif
    output logic             level_c,
    output logic             evt_c
);

    logic [NSYNC-1:0] sync_q;
    logic             s;
    logic             lvl;
    logic             p_q;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) sync_q <= '0;
        else         sync_q <= {sync_q[NSYNC-2:0], pin};
    end

    assign s = sync_q[NSYNC-1];

`ifdef RV_GPIO_DEBOUNCE_EN
    logic [DBC_W-1:0] cnt_q;
    logic             d_q;

    // cnt_q counts cycles s has disagreed with d_q; the new level is passed
    // through combinationally on the (dbc+1)-th cycle so dbc=0 adds no latency.
    always_comb begin
        lvl = d_q;
        if ((s != d_q) && (cnt_q >= dbc)) lvl = s;
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            cnt_q <= '0;
            d_q   <= 1'b0;
        end else begin
            d_q   <= lvl;
            cnt_q <= (s == lvl) ? '0 : DBC_W'(cnt_q + 1'b1);
        end
    end
`else
    assign lvl = s;
`endif

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) p_q <= 1'b0;
        else         p_q <= lvl;
    end

    assign level_c = lvl;
    assign evt_c   = edge_sel ? (~lvl & p_q) : (lvl & ~p_q);

endmodule

// File: rtl/rv_gpio.sv
// GPIO peripheral top: register file, bus decode, registered read mux and irq.
// Optional RV_GPIO_DEBOUNCE_EN adds a DBC register written through offset 0x04.
module rv_gpio
    import rv_gpio_pkg::*;
#(
    parameter int unsigned NBITS = 8,
    parameter int unsigned NSYNC = 2,
    parameter int unsigned DBC_W = 16
) (
    input  logic             clk,
    input  logic             xreset,
    input  logic [4:0]       adr,
    input  logic             cs,
    input  logic             rdy,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [31:0]      dw,
    output logic [31:0]      dr,
    output logic             irq,
    input  logic [NBITS-1:0] gpio_i,
    output logic [NBITS-1:0] gpio_o,
    output logic [NBITS-1:0] gpio_oe
);

    localparam logic [2:0] R_OUT  = reg_idx(GPIO_OUT);
    localparam logic [2:0] R_IN   = reg_idx(GPIO_IN);
    localparam logic [2:0] R_DIR  = reg_idx(GPIO_DIR);
    localparam logic [2:0] R_IEN  = reg_idx(GPIO_IEN);
    localparam logic [2:0] R_STAT = reg_idx(GPIO_STAT);
    localparam logic [2:0] R_EDGE = reg_idx(GPIO_EDGE);
    localparam logic [2:0] R_SET  = reg_idx(GPIO_SET);
    localparam logic [2:0] R_CLR  = reg_idx(GPIO_CLR);

    logic [31:0]      wmask;
    logic [31:0]      wbits;
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       ridx;
    logic [NBITS-1:0] msk;
    logic [NBITS-1:0] wsel;

    logic [NBITS-1:0] out_q, dir_q, ien_q, stat_q, edge_q;
    logic [NBITS-1:0] out_d, dir_d, ien_d, stat_d, edge_d, stat_clr;
    logic [NBITS-1:0] lvl, evt;
    logic [31:0]      rd_c;

    assign wmask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    assign wbits = dw & wmask;
    assign wr_en = cs & rdy & (|we);
    assign rd_en = cs & rdy & re;
    assign ridx  = adr[4:2];
    assign msk   = wmask[NBITS-1:0];
    assign wsel  = wbits[NBITS-1:0];

    logic unused_bits;
    assign unused_bits = ^{adr[1:0], wmask, wbits};

`ifdef RV_GPIO_DEBOUNCE_EN
    logic [DBC_W-1:0] dbc_q;

    // DBC shares the IN offset on writes only; reads of 0x04 still return IN.
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            dbc_q <= '0;
        end else if (wr_en && (ridx == R_IN)) begin
            dbc_q <= DBC_W'((32'(dbc_q) & ~wmask) | wbits);
        end
    end
`else
    logic [DBC_W-1:0] unused_dbc;
    assign unused_dbc = '0;
`endif

    for (genvar i = 0; i < NBITS; i++) begin : g_pin
        rv_gpio_in #(
            .NSYNC(NSYNC)
`ifdef RV_GPIO_DEBOUNCE_EN
            ,
            .DBC_W(DBC_W)
`endif
        ) u_in (
            .clk     (clk),
            .xreset  (xreset),
            .pin     (gpio_i[i]),
            .edge_sel(edge_q[i]),
`ifdef RV_GPIO_DEBOUNCE_EN
            .dbc     (dbc_q),
`endif
            .level_c (lvl[i]),
            .evt_c   (evt[i])
        );
    end

    // Next-state of the register file; a new event overrides a same-cycle W1C.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ien_d    = ien_q;
        edge_d   = edge_q;
        stat_clr = '0;
        if (wr_en) begin
            case (ridx)
                R_OUT:   out_d    = (out_q & ~msk) | wsel;
                R_DIR:   dir_d    = (dir_q & ~msk) | wsel;
                R_IEN:   ien_d    = (ien_q & ~msk) | wsel;
                R_EDGE:  edge_d   = (edge_q & ~msk) | wsel;
                R_STAT:  stat_clr = wsel;
                R_SET:   out_d    = out_q | wsel;
                R_CLR:   out_d    = out_q & ~wsel;
                default: ;
            endcase
        end
        stat_d = (stat_q & ~stat_clr) | evt;
    end

    always_comb begin
        rd_c = '0;
        case (ridx)
            R_OUT:   rd_c = 32'(out_q);
            R_IN:    rd_c = 32'(lvl);
            R_DIR:   rd_c = 32'(dir_q);
            R_IEN:   rd_c = 32'(ien_q);
            R_STAT:  rd_c = 32'(stat_q);
            R_EDGE:  rd_c = 32'(edge_q);
            default: rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            stat_q <= '0;
            edge_q <= '0;
            irq    <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ien_q  <= ien_d;
            stat_q <= stat_d;
            edge_q <= edge_d;
            irq    <= |(stat_d & ien_d);
        end
    end

    // Read data samples pre-write state and holds until the next qualified read.
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)    dr <= '0;
        else if (rd_en) dr <= rd_c;
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

endmodule

// File: tb/tb_rv_gpio.sv
// Scoreboard bench for rv_gpio (NBITS=12); debounce checks run when RV_GPIO_DEBOUNCE_EN is defined.
module tb_rv_gpio;

    localparam int unsigned NB = 12;

    logic          clk = 1'b0;
    logic          xreset = 1'b0;
    logic [4:0]    adr = '0;
    logic          cs = 1'b0;
    logic          rdy = 1'b0;
    logic [3:0]    we = '0;
    logic          re = 1'b0;
    logic [31:0]   dw = '0;
    logic [31:0]   dr;
    logic          irq;
    logic [NB-1:0] gpio_i = 12'h0A5;
    logic [NB-1:0] gpio_o;
    logic [NB-1:0] gpio_oe;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [4:0]  tag_q[$];
    logic        rd_seen = 1'b0;

    rv_gpio #(.NBITS(NB), .NSYNC(2), .DBC_W(16)) dut (
        .clk    (clk),
        .xreset (xreset),
        .adr    (adr),
        .cs     (cs),
        .rdy    (rdy),
        .we     (we),
        .re     (re),
        .dw     (dw),
        .dr     (dr),
        .irq    (irq),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .gpio_oe(gpio_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_seen <= cs & re & rdy;

    // Monitor: dr is valid the cycle after a qualified read.
    initial begin
        logic [31:0] e;
        logic [4:0]  t;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL read unexpected: got %08h want none", dr);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (dr !== e) begin
                        bad++;
                        $display("FAIL read @%02h: got %08h want %08h", t, dr, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        adr = a; dw = d; we = be; cs = 1'b1; rdy = 1'b1;
        step();
        cs = 1'b0; we = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [31:0] e);
        adr = a; re = 1'b1; cs = 1'b1; rdy = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(a);
        step();
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic bus_wr_rd(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
        adr = a; dw = d; we = 4'hF; re = 1'b1; cs = 1'b1; rdy = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(a);
        step();
        cs = 1'b0; re = 1'b0; we = '0;
    endtask

    initial begin
        // Reset state
        steps(3);
        chk("rst gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst gpio_o", 32'(gpio_o), 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst dr", dr, 32'h0);
        xreset = 1'b1;
        steps(3);
        bus_rd(5'h04, 32'h0000_00A5);

        // Direction, output, set and clear
        bus_wr(5'h08, 32'h0000_00FF, 4'hF);
        chk("dir", 32'(gpio_oe), 32'h0FF);
        bus_wr(5'h00, 32'h0000_000F, 4'hF);
        chk("out", 32'(gpio_o), 32'h00F);
        bus_wr(5'h18, 32'h0000_00F0, 4'hF);
        chk("set", 32'(gpio_o), 32'h0FF);
        bus_wr(5'h1C, 32'h0000_0003, 4'hF);
        chk("clr", 32'(gpio_o), 32'h0FC);
        bus_rd(5'h18, 32'h0);
        bus_rd(5'h1C, 32'h0);
        bus_rd(5'h00, 32'h0000_00FC);
        steps(3);
        chk("dr hold", dr, 32'h0000_00FC);

        // Same-cycle write and read returns the old value
        bus_wr_rd(5'h00, 32'h0, 32'h0000_00FC);
        chk("wr+rd out", 32'(gpio_o), 32'h0);
        bus_rd(5'h00, 32'h0);

        // Rising edge interrupt and W1C
        gpio_i = 12'h0A4;
        steps(4);
        bus_wr(5'h10, 32'h0000_0FFF, 4'hF);
        bus_rd(5'h10, 32'h0);
        bus_wr(5'h14, 32'h0, 4'hF);
        bus_wr(5'h0C, 32'h0000_0001, 4'hF);
        chk("irq idle", 32'(irq), 32'h0);
        gpio_i = 12'h0A5;
        steps(2);
        chk("irq early", 32'(irq), 32'h0);
        step();
        chk("irq rise", 32'(irq), 32'h1);
        bus_rd(5'h10, 32'h0000_0001);
        bus_wr(5'h10, 32'h0000_0002, 4'hF);
        chk("irq w1c other", 32'(irq), 32'h1);
        bus_rd(5'h10, 32'h0000_0001);
        bus_wr(5'h10, 32'h0000_0001, 4'hF);
        chk("irq w1c", 32'(irq), 32'h0);

        // Falling edge ignored with EDGE=0; W1C colliding with a new event
        gpio_i = 12'h0A4;
        steps(4);
        chk("irq fall ignored", 32'(irq), 32'h0);
        gpio_i = 12'h0A5;
        steps(2);
        bus_wr(5'h10, 32'h0000_0001, 4'hF);
        chk("irq set wins", 32'(irq), 32'h1);
        bus_rd(5'h10, 32'h0000_0001);

        // IEN gates irq on the next cycle
        bus_wr(5'h0C, 32'h0, 4'hF);
        chk("irq ien off", 32'(irq), 32'h0);
        bus_wr(5'h0C, 32'h0000_0001, 4'hF);
        chk("irq ien on", 32'(irq), 32'h1);

        // Falling edge with EDGE=1
        bus_wr(5'h14, 32'h0000_0001, 4'hF);
        bus_wr(5'h10, 32'h0000_0001, 4'hF);
        chk("irq pre fall", 32'(irq), 32'h0);
        gpio_i = 12'h0A4;
        steps(3);
        chk("irq fall", 32'(irq), 32'h1);
        bus_rd(5'h10, 32'h0000_0001);
        bus_rd(5'h14, 32'h0000_0001);

        // Byte enables and bits above NBITS
        bus_wr(5'h08, 32'h0, 4'hF);
        bus_wr(5'h08, 32'h0000_AB00, 4'b0010);
        chk("dir partial", 32'(gpio_oe), 32'hB00);
        bus_rd(5'h08, 32'h0000_0B00);
        bus_wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        bus_rd(5'h00, 32'h0000_0FFF);
        bus_wr(5'h00, 32'h1234_5678, 4'b0001);
        bus_rd(5'h00, 32'h0000_0F78);
        bus_wr(5'h0C, 32'hFFFF_FFFF, 4'b0100);
        bus_rd(5'h0C, 32'h0000_0001);
`ifndef RV_GPIO_DEBOUNCE_EN
        bus_wr(5'h04, 32'h0000_0FFF, 4'hF);
        bus_rd(5'h04, 32'h0000_00A4);
`else
        // Debounce with DBC=3
        bus_wr(5'h04, 32'h0000_0003, 4'hF);
        bus_rd(5'h04, 32'h0000_00A4);
        bus_wr(5'h10, 32'h0000_0FFF, 4'hF);
        bus_wr(5'h0C, 32'h0000_0002, 4'hF);
        chk("dbc irq idle", 32'(irq), 32'h0);
        gpio_i = 12'h0A6;
        steps(2);
        gpio_i = 12'h0A4;
        steps(8);
        chk("dbc glitch irq", 32'(irq), 32'h0);
        bus_rd(5'h10, 32'h0);
        gpio_i = 12'h0A6;
        steps(10);
        chk("dbc stable irq", 32'(irq), 32'h1);
        bus_rd(5'h10, 32'h0000_0002);
        bus_rd(5'h04, 32'h0000_00A6);
        gpio_i = 12'h0A4;
        steps(2);
`endif

        // Asynchronous reset mid-cycle
        bus_rd(5'h00, 32'h0000_0F78);
        chk("irq before rst", 32'(irq), 32'h1);
        @(posedge clk);
        #3;
        xreset = 1'b0;
        #1;
        chk("async rst irq", 32'(irq), 32'h0);
        chk("async rst gpio_o", 32'(gpio_o), 32'h0);
        chk("async rst gpio_oe", 32'(gpio_oe), 32'h0);
        chk("async rst dr", dr, 32'h0);
        step();
        xreset = 1'b1;
        bus_rd(5'h00, 32'h0);
        bus_rd(5'h08, 32'h0);
        bus_rd(5'h0C, 32'h0);
        bus_rd(5'h14, 32'h0);

        steps(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
